kadai3_arb: RTL

KADAI3_ARB -- requirements
Module: kadai3_arb

---
 rtl/kadai3_arb.sv | 115 +++++++++++
 1 files changed

// File: rtl/kadai3_arb.sv
// Two-requester round-robin write arbiter in front of a shared multiply FIFO,
// with an in-order tag queue that routes each returning product to its owner.
module kadai3_arb #(
    parameter int unsigned DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        REQ_A,
    input  logic        REQ_B,
    input  logic [15:0] DIN_A,
    input  logic [15:0] DIN_B,
    output logic        GNT_A,
    output logic        GNT_B,
    input  logic        RDY_A,
    input  logic        RDY_B,
    output logic [15:0] DOUT_A,
    output logic [15:0] DOUT_B,
    output logic        VALID_A,
    output logic        VALID_B,
    output logic        FIFO_WR,
    output logic        FIFO_RD,
    output logic [15:0] FIFO_DIN,
    input  logic [15:0] FIFO_DOUT,
    input  logic        FIFO_EMPTY,
    input  logic        FIFO_FULL,
    input  logic        FIFO_VALID,
    output logic [4:0]  OCC
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = 5;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

    logic             pri;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             tagq;
    logic             tag_mem [DEPTH];

    logic can_wr;
    logic gnt_a;
    logic gnt_b;
    logic head_tag;
    logic head_rdy;
    logic fifo_rd;
    logic fifo_wr;

    // Write side: both grants gated by room in the FIFO and in the tag queue.
    always_comb begin
        can_wr = ~RST & ~FIFO_FULL & (occ < OCC_MAX);
        gnt_a  = can_wr & REQ_A & (~pri | ~REQ_B);
        gnt_b  = can_wr & REQ_B & ( pri | ~REQ_A);
        fifo_wr = gnt_a | gnt_b;
    end

    // Read side: strictly in order, so a stalled head owner stalls everyone.
    always_comb begin
        head_tag = tag_mem[rd_ptr];
        head_rdy = head_tag ? RDY_B : RDY_A;
        fifo_rd  = ~RST & ~FIFO_EMPTY & (occ != '0) & head_rdy;
    end

    assign GNT_A    = gnt_a;
    assign GNT_B    = gnt_b;
    assign FIFO_WR  = fifo_wr;
    assign FIFO_RD  = fifo_rd;
    assign FIFO_DIN = gnt_b ? DIN_B : DIN_A;
    assign OCC      = occ;

    // Products come back one cycle after the read; tagq names their owner.
    assign VALID_A = ~RST & FIFO_VALID & ~tagq;
    assign VALID_B = ~RST & FIFO_VALID &  tagq;
    assign DOUT_A  = FIFO_DOUT;
    assign DOUT_B  = FIFO_DOUT;

    always_ff @(posedge CLK) begin
        if (RST) begin
            pri    <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            tagq   <= 1'b0;
        end else begin
            if (gnt_a) begin
                pri <= 1'b1;
            end else if (gnt_b) begin
                pri <= 1'b0;
            end
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (fifo_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                tagq   <= head_tag;
            end
            case ({fifo_wr, fifo_rd})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid occ.
    always_ff @(posedge CLK) begin
        if (!RST && fifo_wr) begin
            tag_mem[wr_ptr] <= gnt_b;
        end
    end

    a_one_grant : assert property (@(posedge CLK) disable iff (RST) !(GNT_A && GNT_B));
    a_occ_range : assert property (@(posedge CLK) disable iff (RST) OCC <= OCC_MAX);

endmodule
